rti_return_handler: RTL and testbench
=====================================

// Module: rti_return_handler
// PURPOSE
//  Exit half of the interrupt protocol. The entry handler pushes PC and flags, then redirects fetch to the IVT.
//  This block sequences RTI: it stalls fetch and injects NOP, POP-FLAGS and POP-PC into decode.
//  It captures the popped values from the memory stage, then redirects fetch to the restored PC and restores the flags.
//  It sits beside the interrupt handler between the fetch and decode stages.
// PARAMETERS
//  BUBBLE_CYCLES  1    NOPs injected after RTI decode, before the first pop (drains the jump slot)
//  WAIT_LIMIT     8    max cycles in WAIT for both pop results; exceeding it aborts
//  PC_W           32   PC width
//  FLAG_W         4    flag register width
// PORTS
//  clk                 in   1       clock, all logic on posedge
//  rst                 in   1       synchronous reset, active-high
//  rtiDetected         in   1       decode holds an RTI this cycle
//  interruptBusy       in   1       interrupt entry sequence in progress
//  popFlagsValid       in   1       memory stage returns popped flags this cycle
//  popFlagsData        in   FLAG_W  popped flags
//  popPcValid          in   1       memory stage returns popped PC this cycle
//  popPcData           in   PC_W    popped PC
//  stallFetch          out  1       hold PC and fetch register
//  injectValid         out  1       decode uses injectInstruction instead of the fetched word
//  injectInstruction   out  16      instruction forced into decode
//  restoreFlagsValid   out  1       one-cycle pulse: load restoreFlags into CCR
//  restoreFlags        out  FLAG_W  flags to restore
//  rtiRedirect         out  1       one-cycle pulse: fetch loads rtiRedirectPC
//  rtiRedirectPC       out  PC_W    return address
//  rtiError            out  1       one-cycle pulse: WAIT_LIMIT exceeded
//  busy                out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; injectInstruction=NOP; captured regs and valid bits cleared.
//  Reset mid-sequence abandons it immediately, with no redirect and no flag restore.
//  Outputs are registered, i.e. decoded from the current state and registers.
//  States and transitions:
//   IDLE: rtiDetected&!interruptBusy -> BUBBLE next cycle.
//         rtiDetected&interruptBusy -> stay; RTI is re-sampled each cycle until interruptBusy falls.
//   BUBBLE: stall=1, inject NOP for BUBBLE_CYCLES cycles (counter), then -> POPF. BUBBLE_CYCLES=0 skips to POPF.
//   POPF: stall=1, inject POPF_INSTR for 1 cycle -> POPPC.
//   POPPC: stall=1, inject POPPC_INSTR for 1 cycle -> WAIT.
//   WAIT: stall=1, inject NOP; counter counts cycles in WAIT.
//     both captured -> REDIRECT.
//     counter==WAIT_LIMIT with either missing -> ABORT.
//   REDIRECT: 1 cycle: rtiRedirect=1, rtiRedirectPC=capturedPC, restoreFlagsValid=1, restoreFlags=capturedFlags;
//     stall=1, inject NOP -> IDLE.
//   ABORT: 1 cycle: rtiError=1, stall=1, inject NOP -> IDLE.
//  Capture rules:
//   popFlagsValid/popPcValid are sampled in POPF, POPPC and WAIT; they are ignored in other states.
//   Results may arrive in either order or in the same cycle.
//   A second valid before REDIRECT overwrites the captured value (last wins).
//   A result arriving in the same cycle WAIT sees the other one completes the pair -> REDIRECT next cycle.
//  rtiDetected is ignored while busy; no nesting.
//  Latency with BUBBLE_CYCLES=1 and pops returned 2 cycles after POPPC: RTI sampled T0, BUBBLE T1, POPF T2,
//   POPPC T3, WAIT T4-T5, REDIRECT T6. stallFetch is high T1-T6 and low at T7.
//  Wait counter width is clog2(WAIT_LIMIT+1); it saturates and never wraps.
// STRUCTURE
//  Shared package int_pkg:
//   constants NOP_INSTR=16'b0000011111111000, POPF_INSTR=16'hF500, POPPC_INSTR=16'hF580
//   state encoding: IDLE, BUBBLE, POPF, POPPC, WAIT, REDIRECT, ABORT
//   flag-width constant
//  Optional sub-module rti_pop_capture: two capture registers with valid bits, clear, and both-valid flag.
//  The rest is one FSM plus counters.
// TESTING
//  1 Nominal: rtiDetected at T0; popFlags=4'b1010 at T4, popPc=32'h0000_0123 at T5.
//    -> rtiRedirect and restoreFlagsValid at T6 with PC=0x123, flags=1010; stall low T7.
//  2 Same-cycle and reversed order: popPc at T4, then popPc=0x200 and popFlags together at T5.
//    -> REDIRECT T6 with PC=0x200 (last wins).
//  3 Timeout, WAIT_LIMIT=8: popFlags only, no popPc.
//    -> rtiError pulses once after 8 WAIT cycles; no redirect; busy low next cycle.
//  4 Interrupt overlap: rtiDetected with interruptBusy=1 for 3 cycles.
//    -> stays IDLE; BUBBLE starts the cycle after interruptBusy=0 with rtiDetected still high.
//  5 Reset in WAIT: rst=1 for 1 cycle.
//    -> all outputs 0 next cycle; later pop valids are ignored; new RTI runs normally.
//  6 Spurious: pop valids in IDLE, and rtiDetected during WAIT.
//    -> no capture, no restart, sequence unaffected.

Source files
------------

// File: rtl/int_pkg.sv
// Shared interrupt-protocol definitions: injected opcodes, RTI sequencer state
// encoding and default widths used by the entry and return handlers.
package int_pkg;

   localparam logic [15:0] NOP_INSTR   = 16'b0000011111111000;
   localparam logic [15:0] POPF_INSTR  = 16'hF500;
   localparam logic [15:0] POPPC_INSTR = 16'hF580;

   localparam int FLAG_W_DEF = 4;
   localparam int PC_W_DEF   = 32;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_BUBBLE   = 3'd1,
      ST_POPF     = 3'd2,
      ST_POPPC    = 3'd3,
      ST_WAIT     = 3'd4,
      ST_REDIRECT = 3'd5,
      ST_ABORT    = 3'd6
   } rti_state_e;

   // Width of a counter that must hold max_val without wrapping (never below 1 bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rti_pop_capture.sv
// Holding registers for the popped flags and PC. Exposes next-cycle values so the
// sequencer can register its redirect outputs in the same edge the pair completes.
module rti_pop_capture #(
   parameter int PC_W   = 32,
   parameter int FLAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              sample_i,
   input  logic              flags_valid_i,
   input  logic [FLAG_W-1:0] flags_data_i,
   input  logic              pc_valid_i,
   input  logic [PC_W-1:0]   pc_data_i,
   output logic [FLAG_W-1:0] flags_d_o,
   output logic [PC_W-1:0]   pc_d_o,
   output logic              both_d_o
);

   logic              flags_v_q, flags_v_d;
   logic              pc_v_q, pc_v_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic [PC_W-1:0]   pc_q, pc_d;

   // Next capture state: a later valid overwrites the held value (last wins).
   always_comb begin
      flags_v_d = flags_v_q;
      flags_d   = flags_q;
      pc_v_d    = pc_v_q;
      pc_d      = pc_q;
      if (clear_i) begin
         flags_v_d = 1'b0;
         flags_d   = '0;
         pc_v_d    = 1'b0;
         pc_d      = '0;
      end else if (sample_i) begin
         if (flags_valid_i) begin
            flags_v_d = 1'b1;
            flags_d   = flags_data_i;
         end else begin
            flags_v_d = flags_v_q;
            flags_d   = flags_q;
         end
         if (pc_valid_i) begin
            pc_v_d = 1'b1;
            pc_d   = pc_data_i;
         end else begin
            pc_v_d = pc_v_q;
            pc_d   = pc_q;
         end
      end else begin
         flags_v_d = flags_v_q;
         pc_v_d    = pc_v_q;
      end
   end

   // Capture registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_v_q <= 1'b0;
         flags_q   <= '0;
         pc_v_q    <= 1'b0;
         pc_q      <= '0;
      end else begin
         flags_v_q <= flags_v_d;
         flags_q   <= flags_d;
         pc_v_q    <= pc_v_d;
         pc_q      <= pc_d;
      end
   end

   assign flags_d_o = flags_d;
   assign pc_d_o    = pc_d;
   assign both_d_o  = flags_v_d & pc_v_d;

endmodule

// File: rtl/rti_return_handler.sv
// RTI sequencer: stalls fetch, injects NOP/POPF/POPPC into decode, collects the
// popped flags and PC, then redirects fetch and restores flags (or aborts on timeout).
module rti_return_handler
   import int_pkg::*;
#(
   parameter int BUBBLE_CYCLES = 1,
   parameter int WAIT_LIMIT    = 8,
   parameter int PC_W          = PC_W_DEF,
   parameter int FLAG_W        = FLAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rtiDetected,
   input  logic              interruptBusy,
   input  logic              popFlagsValid,
   input  logic [FLAG_W-1:0] popFlagsData,
   input  logic              popPcValid,
   input  logic [PC_W-1:0]   popPcData,
   output logic              stallFetch,
   output logic              injectValid,
   output logic [15:0]       injectInstruction,
   output logic              restoreFlagsValid,
   output logic [FLAG_W-1:0] restoreFlags,
   output logic              rtiRedirect,
   output logic [PC_W-1:0]   rtiRedirectPC,
   output logic              rtiError,
   output logic              busy
);

   localparam int BUB_W  = cnt_width(BUBBLE_CYCLES);
   localparam int WAIT_W = cnt_width(WAIT_LIMIT);

   rti_state_e        state_q, state_d;
   logic [BUB_W-1:0]  bub_cnt_q, bub_cnt_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic              stall_q, inject_valid_q, busy_q;
   logic [15:0]       inject_instr_q;
   logic              restore_valid_q, redirect_q, error_q;
   logic [FLAG_W-1:0] restore_flags_q;
   logic [PC_W-1:0]   redirect_pc_q;

   logic              cap_clear_s, cap_sample_s, cap_both_s;
   logic [FLAG_W-1:0] cap_flags_s;
   logic [PC_W-1:0]   cap_pc_s;

   assign cap_clear_s  = (state_q == ST_IDLE);
   assign cap_sample_s = (state_q == ST_POPF) || (state_q == ST_POPPC) || (state_q == ST_WAIT);

   rti_pop_capture #(
      .PC_W   (PC_W),
      .FLAG_W (FLAG_W)
   ) u_capture (
      .clk           (clk),
      .rst           (rst),
      .clear_i       (cap_clear_s),
      .sample_i      (cap_sample_s),
      .flags_valid_i (popFlagsValid),
      .flags_data_i  (popFlagsData),
      .pc_valid_i    (popPcValid),
      .pc_data_i     (popPcData),
      .flags_d_o     (cap_flags_s),
      .pc_d_o        (cap_pc_s),
      .both_d_o      (cap_both_s)
   );

   // Next-state and counter logic; a pair completing in WAIT beats the timeout.
   always_comb begin
      state_d    = state_q;
      bub_cnt_d  = bub_cnt_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rtiDetected && !interruptBusy) begin
               bub_cnt_d = '0;
               state_d   = (BUBBLE_CYCLES == 0) ? ST_POPF : ST_BUBBLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUBBLE: begin
            if ((int'(bub_cnt_q) + 1) >= BUBBLE_CYCLES) begin
               state_d = ST_POPF;
            end else begin
               bub_cnt_d = bub_cnt_q + BUB_W'(1);
            end
         end
         ST_POPF:  state_d = ST_POPPC;
         ST_POPPC: begin
            wait_cnt_d = WAIT_W'(1);
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (cap_both_s) begin
               state_d = ST_REDIRECT;
            end else if (wait_cnt_q >= WAIT_W'(WAIT_LIMIT)) begin
               state_d = ST_ABORT;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_REDIRECT: state_d = ST_IDLE;
         ST_ABORT:    state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // State, counters and outputs registered together from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         bub_cnt_q       <= '0;
         wait_cnt_q      <= '0;
         stall_q         <= 1'b0;
         inject_valid_q  <= 1'b0;
         busy_q          <= 1'b0;
         inject_instr_q  <= NOP_INSTR;
         restore_valid_q <= 1'b0;
         restore_flags_q <= '0;
         redirect_q      <= 1'b0;
         redirect_pc_q   <= '0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         bub_cnt_q       <= bub_cnt_d;
         wait_cnt_q      <= wait_cnt_d;
         stall_q         <= (state_d != ST_IDLE);
         inject_valid_q  <= (state_d != ST_IDLE);
         busy_q          <= (state_d != ST_IDLE);
         case (state_d)
            ST_POPF:  inject_instr_q <= POPF_INSTR;
            ST_POPPC: inject_instr_q <= POPPC_INSTR;
            default:  inject_instr_q <= NOP_INSTR;
         endcase
         restore_valid_q <= (state_d == ST_REDIRECT);
         restore_flags_q <= (state_d == ST_REDIRECT) ? cap_flags_s : '0;
         redirect_q      <= (state_d == ST_REDIRECT);
         redirect_pc_q   <= (state_d == ST_REDIRECT) ? cap_pc_s : '0;
         error_q         <= (state_d == ST_ABORT);
      end
   end

   assign stallFetch        = stall_q;
   assign injectValid       = inject_valid_q;
   assign injectInstruction = inject_instr_q;
   assign restoreFlagsValid = restore_valid_q;
   assign restoreFlags      = restore_flags_q;
   assign rtiRedirect       = redirect_q;
   assign rtiRedirectPC     = redirect_pc_q;
   assign rtiError          = error_q;
   assign busy              = busy_q;

endmodule

// File: tb/tb_rti_return_handler.sv
// Table-driven bench for rti_return_handler: each vector names the sequencer phase
// expected after its clock edge; a scoreboard queue holds the expected outputs.
module tb_rti_return_handler;

   typedef enum int {S_I, S_B, S_F, S_P, S_W, S_R, S_A} es_t;

   typedef struct packed {
      logic        stall;
      logic        iv;
      logic [15:0] ins;
      logic        rfv;
      logic [3:0]  rf;
      logic        redir;
      logic [31:0] rpc;
      logic        err;
      logic        busy;
   } out_t;

   typedef struct {
      logic        rst;
      logic        rti;
      logic        ib;
      logic        fv;
      logic [3:0]  fd;
      logic        pv;
      logic [31:0] pd;
      es_t         es;
      logic [3:0]  ef;
      logic [31:0] epc;
      string       tag;
   } vec_t;

   typedef struct {
      out_t  exp;
      string tag;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rtiDetected, interruptBusy;
   logic        popFlagsValid, popPcValid;
   logic [3:0]  popFlagsData;
   logic [31:0] popPcData;
   logic        stallFetch, injectValid, restoreFlagsValid, rtiRedirect, rtiError, busy;
   logic [15:0] injectInstruction;
   logic [3:0]  restoreFlags;
   logic [31:0] rtiRedirectPC;

   int   checks = 0;
   int   errors = 0;
   sb_t  sbq[$];
   vec_t tbl[$];

   always #5 clk = ~clk;

   rti_return_handler #(
      .BUBBLE_CYCLES (1),
      .WAIT_LIMIT    (8),
      .PC_W          (32),
      .FLAG_W        (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rtiDetected       (rtiDetected),
      .interruptBusy     (interruptBusy),
      .popFlagsValid     (popFlagsValid),
      .popFlagsData      (popFlagsData),
      .popPcValid        (popPcValid),
      .popPcData         (popPcData),
      .stallFetch        (stallFetch),
      .injectValid       (injectValid),
      .injectInstruction (injectInstruction),
      .restoreFlagsValid (restoreFlagsValid),
      .restoreFlags      (restoreFlags),
      .rtiRedirect       (rtiRedirect),
      .rtiRedirectPC     (rtiRedirectPC),
      .rtiError          (rtiError),
      .busy              (busy)
   );

   // Expected output bundle for a given sequencer phase.
   function automatic out_t model(input es_t s, input logic [3:0] ef, input logic [31:0] epc);
      out_t o;
      o.stall = (s != S_I);
      o.iv    = (s != S_I);
      o.busy  = (s != S_I);
      o.ins   = (s == S_F) ? 16'hF500 : ((s == S_P) ? 16'hF580 : 16'h07F8);
      o.rfv   = (s == S_R);
      o.redir = (s == S_R);
      o.rf    = (s == S_R) ? ef : 4'h0;
      o.rpc   = (s == S_R) ? epc : 32'h0;
      o.err   = (s == S_A);
      return o;
   endfunction

   task automatic add(input string tag, input logic r, input logic rti, input logic ib,
                      input logic fv, input logic [3:0] fd, input logic pv, input logic [31:0] pd,
                      input es_t es, input logic [3:0] ef = 4'h0, input logic [31:0] epc = 32'h0);
      vec_t v;
      v.rst = r; v.rti = rti; v.ib = ib; v.fv = fv; v.fd = fd; v.pv = pv; v.pd = pd;
      v.es = es; v.ef = ef; v.epc = epc; v.tag = tag;
      tbl.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      sb_t e;
      @(negedge clk);
      rst           = v.rst;
      rtiDetected   = v.rti;
      interruptBusy = v.ib;
      popFlagsValid = v.fv;
      popFlagsData  = v.fd;
      popPcValid    = v.pv;
      popPcData     = v.pd;
      e.exp = model(v.es, v.ef, v.epc);
      e.tag = v.tag;
      sbq.push_back(e);
   endtask

   task automatic run_table();
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
      tbl.delete();
   endtask

   // Scoreboard: compare DUT outputs just after each edge against the queued expectation.
   always @(posedge clk) begin : checker_blk
      sb_t  e;
      out_t a;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         a = '{stallFetch, injectValid, injectInstruction, restoreFlagsValid, restoreFlags,
               rtiRedirect, rtiRedirectPC, rtiError, busy};
         checks++;
         if (a !== e.exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", e.tag, a, e.exp);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rtiDetected = 1'b0; interruptBusy = 1'b0;
      popFlagsValid = 1'b0; popFlagsData = 4'h0; popPcValid = 1'b0; popPcData = 32'h0;

      // reset state, then nominal return with pops at T4 / T5
      add("reset",     1'b1, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      add("idle",      1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      add("nom_t0",    1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("nom_t1",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("nom_t2",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("nom_t3",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("nom_t4",    1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 32'h0, S_W);
      add("nom_t5",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 32'h0000_0123, S_R, 4'b1010, 32'h0000_0123);
      add("nom_t6",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      // reversed order, then PC overwritten in the same cycle flags arrive
      add("ord_t0",    1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("ord_t1",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("ord_t2",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("ord_t3",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("ord_t4",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 32'h0000_0100, S_W);
      add("ord_t5",    1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 1'b1, 32'h0000_0200, S_R, 4'b0101, 32'h0000_0200);
      add("ord_t6",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      // interrupt overlap holds IDLE until interruptBusy drops
      for (int i = 0; i < 3; i++)
         add("ovl_hold", 1'b0, 1'b1, 1'b1, 1'b0, 4'h0,  1'b0, 32'h0, S_I);
      add("ovl_go",    1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("ovl_popf",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("ovl_poppc", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("ovl_wait",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("ovl_both",  1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b1, 32'h0000_0ABC, S_R, 4'b0011, 32'h0000_0ABC);
      add("ovl_done",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      // spurious pops in IDLE/BUBBLE and RTI during WAIT are ignored
      add("spu_idle",  1'b0, 1'b0, 1'b0, 1'b1, 4'hF,    1'b1, 32'h0000_DEAD, S_I);
      add("spu_t0",    1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("spu_bub",   1'b0, 1'b0, 1'b0, 1'b1, 4'hE,    1'b1, 32'h0000_BEEF, S_F);
      add("spu_popf",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("spu_poppc", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("spu_rti1",  1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("spu_rti2",  1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("spu_flags", 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110, 1'b0, 32'h0, S_W);
      add("spu_pc",    1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 32'h0000_0456, S_R, 4'b0110, 32'h0000_0456);
      add("spu_done",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      run_table();

      // timeout: flags arrive in POPF, PC never does; ABORT after 8 WAIT cycles
      add("to_t0",     1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("to_t1",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("to_popf",   1'b0, 1'b0, 1'b0, 1'b1, 4'b1100, 1'b0, 32'h0, S_P);
      add("to_enter",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      for (int i = 1; i < 8; i++)
         add("to_wait",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,  1'b0, 32'h0, S_W);
      add("to_abort",  1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_A);
      add("to_idle",   1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      run_table();

      // reset while waiting, stale pops ignored, then a clean return
      add("rw_t0",     1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("rw_t1",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("rw_t2",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("rw_t3",     1'b0, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 32'h0, S_W);
      add("rw_rst",    1'b1, 1'b0, 1'b0, 1'b0, 4'h0,    1'b1, 32'h0000_0999, S_I);
      add("rw_stale",  1'b0, 1'b0, 1'b0, 1'b1, 4'hD,    1'b1, 32'h0000_0888, S_I);
      add("rw_n0",     1'b0, 1'b1, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_B);
      add("rw_n1",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_F);
      add("rw_n2",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_P);
      add("rw_n3",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_W);
      add("rw_n4",     1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 32'h0000_0777, S_R, 4'b1001, 32'h0000_0777);
      add("rw_n5",     1'b0, 1'b0, 1'b0, 1'b0, 4'h0,    1'b0, 32'h0, S_I);
      run_table();

      repeat (3) @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sbq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
